instr_assembler: RTL and testbench

Inverse of the instruction field decoder: takes decoded RISC-V fields (opcode, rd, rs1, rs2, funct3, funct7, immediate, format select) and packs them into a 32-bit RV32I instruction word. Encoded words are written sequentially into the instruction-memory load port through a valid/ready handshake, so a testbench or boot loader can build programs for the single-cycle core from field tuples. Holds an auto-incrementing word address and reports fill level, full, and encode errors.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/instr_encode.sv | 48 ++++
 rtl/instr_assembler.sv | 162 ++++++++++++++++
 tb/tb_instr_assembler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I field-format selects, base opcodes and the
//               assembler control-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Format select values carried on the fmt input
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Base opcodes used when building programs
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Assembler control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode
// Description : Combinational packer from decoded RV32I fields to a 32-bit
//               instruction word, with illegal-format and misaligned-target
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        misalign
);

  // Select the field layout for the requested format; out-of-format imm bits drop
  always_comb begin
    word     = 32'd0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        misalign = imm[0];
      end
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        misalign = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Accepts decoded field tuples, encodes them and streams the
//               words into an instruction-memory load port at sequential
//               word addresses; tracks fill level and flags encode errors.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_fmt,
  output logic              err_align
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] c_last  = c_depth - 1'b1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err_fmt;
  logic              r_err_align;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_misalign;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_load;
  logic              w_advance;
  logic              w_err_fmt;
  logic              w_err_align;

  instr_encode u_encode (
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .word     (w_word),
    .illegal  (w_illegal),
    .misalign (w_misalign)
  );

  assign w_count_inc = r_count + 1'b1;

  // Next-state, handshake and capture decisions; clear blocks acceptance outright
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_err_fmt   = 1'b0;
    w_err_align = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (w_illegal) begin
              w_err_fmt = 1'b1;
            end else begin
              w_load      = 1'b1;
              w_err_align = w_misalign;
              w_state_nxt = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // The last free slot cannot take a follow-on tuple, so gate it here
          in_ready = mem_ready && (r_count != c_last);
          if (mem_ready) begin
            w_advance = 1'b1;
            if (w_count_inc == c_depth) begin
              w_state_nxt = ST_FULL;
            end else if (in_valid && in_ready) begin
              if (w_illegal) begin
                w_err_fmt   = 1'b1;
                w_state_nxt = ST_IDLE;
              end else begin
                w_load      = 1'b1;
                w_err_align = w_misalign;
                w_state_nxt = ST_WRITE;
              end
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State, address, fill count, write data and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_count     <= '0;
      r_err_fmt   <= 1'b0;
      r_err_align <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_count     <= '0;
      r_err_fmt   <= 1'b0;
      r_err_align <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_err_fmt   <= w_err_fmt;
      r_err_align <= w_err_align;
      if (w_advance) begin
        r_count <= w_count_inc;
        r_addr  <= r_addr + 1'b1;   // natural wrap returns to 0 on filling
      end
      if (w_load) begin
        r_wdata <= w_word;
      end
    end
  end

  assign mem_we    = (r_state == ST_WRITE);
  assign full      = (r_state == ST_FULL);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign err_fmt   = r_err_fmt;
  assign err_align = r_err_align;

endmodule
`default_nettype wire

// File: tb/tb_instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_assembler
// Description : Directed self-checking bench for instr_assembler with a
//               four-word memory, covering encoding, handshake, fill and
//               error behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_assembler;
  import riscv_pkg::*;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_fmt;
  logic              err_align;

  int n_checks = 0;
  int n_errors = 0;

  instr_assembler #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .full      (full),
    .err_fmt   (err_fmt),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", mem_wdata,      32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_full",  32'(full),      32'd0);
    check("rst_errs",  32'({err_fmt, err_align}), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    // R add x3,x1,x2
    put(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step(); in_valid = 1'b0;
    check("add_we",    32'(mem_we),   32'd1);
    check("add_addr",  32'(mem_addr), 32'd0);
    check("add_wdata", mem_wdata,     32'h002081B3);
    step();
    check("add_count", 32'(count),    32'd1);
    check("add_done",  32'(mem_we),   32'd0);

    // Back-to-back addi then sw
    pulse_clear();
    check("clr_count", 32'(count), 32'd0);
    put(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    step();
    check("addi_wdata", mem_wdata,     32'hFFF00293);
    check("addi_addr",  32'(mem_addr), 32'd0);
    put(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    check("b2b_ready",  32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("sw_we",    32'(mem_we),   32'd1);
    check("sw_addr",  32'(mem_addr), 32'd1);
    check("sw_wdata", mem_wdata,     32'h0020A423);
    check("sw_count", 32'(count),    32'd1);
    step();
    check("sw_done",  32'(count),    32'd2);

    // beq -4 then jal back-to-back, filling the memory
    put(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    step();
    check("beq_wdata", mem_wdata,     32'hFE000EE3);
    check("beq_addr",  32'(mem_addr), 32'd2);
    check("beq_align", 32'(err_align), 32'd0);
    put(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    step(); in_valid = 1'b0;
    check("jal_wdata", mem_wdata,     32'h001000EF);
    check("jal_addr",  32'(mem_addr), 32'd3);
    check("last_ready", 32'(in_ready), 32'd0);
    step();
    check("full_flag",  32'(full),     32'd1);
    check("full_count", 32'(count),    32'd4);
    check("full_addr",  32'(mem_addr), 32'd0);
    check("full_we",    32'(mem_we),   32'd0);
    check("full_ready", 32'(in_ready), 32'd0);

    // Fifth tuple ignored while full
    put(FMT_U, OP_LUI, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    step();
    check("full_ign_we",    32'(mem_we), 32'd0);
    check("full_ign_count", 32'(count),  32'd4);

    // clear blocks acceptance, then lui lands at address 0
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(in_ready), 32'd0);
    step(); clear = 1'b0;
    check("clr_full",  32'(full),   32'd0);
    check("clr_cnt2",  32'(count),  32'd0);
    check("clr_we",    32'(mem_we), 32'd0);
    step(); in_valid = 1'b0;
    check("lui_wdata", mem_wdata,     32'h12345537);
    check("lui_addr",  32'(mem_addr), 32'd0);
    step();
    check("lui_count", 32'(count), 32'd1);

    // Misaligned branch target still written, bit 0 dropped
    put(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step(); in_valid = 1'b0;
    check("mis_align", 32'(err_align), 32'd1);
    check("mis_we",    32'(mem_we),    32'd1);
    check("mis_wdata", mem_wdata,      32'h00000263);
    check("mis_addr",  32'(mem_addr),  32'd1);
    step();
    check("mis_pulse", 32'(err_align), 32'd0);
    check("mis_count", 32'(count),     32'd2);

    // Stall: mem_ready low for three cycles
    mem_ready = 1'b0;
    put(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_we",    32'(mem_we),   32'd1);
      check("stall_addr",  32'(mem_addr), 32'd2);
      check("stall_wdata", mem_wdata,     32'h002081B3);
      check("stall_ready", 32'(in_ready), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    step();
    check("stall_count", 32'(count),  32'd3);
    check("stall_done",  32'(mem_we), 32'd0);

    // Illegal fmt: error pulse, no write
    put(3'd7, OP_REG, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    step(); in_valid = 1'b0;
    check("ill_err",   32'(err_fmt), 32'd1);
    check("ill_we",    32'(mem_we),  32'd0);
    check("ill_count", 32'(count),   32'd3);
    step();
    check("ill_pulse", 32'(err_fmt), 32'd0);

    // clear abandons a stalled write
    pulse_clear();
    mem_ready = 1'b0;
    put(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step(); in_valid = 1'b0;
    check("abort_we0", 32'(mem_we), 32'd1);
    clear = 1'b1;
    step(); clear = 1'b0;
    check("abort_we",    32'(mem_we),   32'd0);
    check("abort_count", 32'(count),    32'd0);
    check("abort_addr",  32'(mem_addr), 32'd0);

    // Asynchronous reset mid-write
    put(FMT_U, OP_LUI, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    step(); in_valid = 1'b0;
    check("arst_we0", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_we",    32'(mem_we),   32'd0);
    check("arst_wdata", mem_wdata,     32'd0);
    check("arst_count", 32'(count),    32'd0);
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
